rsa_job_arbiter: RTL and testbench

RSA_JOB_ARBITER -- requirements
Module: rsa_job_arbiter

---
 rtl/rsa_pkg.sv | 30 +++
 rtl/rsa_rr_pick.sv | 26 ++
 rtl/rsa_job_arbiter.sv | 146 ++++++++++++++
 tb/tb_rsa_job_arbiter.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rsa_pkg.sv
// rsa_pkg: state encodings, requester indices and defaults for the RSA job arbiter.
// The RSA_ARB_TIMEOUT_EN macro adds the ABORT state used by the timeout path.
package rsa_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_RUN   = 3'd2,
    ST_DONE  = 3'd3
`ifdef RSA_ARB_TIMEOUT_EN
    ,
    ST_ABORT = 3'd4
`endif
  } state_t;

  localparam int REQ_SPI = 0;
  localparam int REQ_PIN = 1;
  localparam int NUM_REQ = 2;

  localparam int DEF_TIMEOUT_CYCLES = 4096;
  localparam int CNT_W = 16;

  function automatic logic [NUM_REQ-1:0] req_onehot(input int idx);
    logic [NUM_REQ-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rsa_rr_pick.sv
// rsa_rr_pick: two-way round-robin winner select, one-hot result.
// On contention the requester that was not served last wins.
module rsa_rr_pick
  import rsa_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic               last_served,
  output logic [NUM_REQ-1:0] winner
);

  always_comb begin
    winner = '0;
    unique case (1'b1)
      (req == 2'b11):
        winner = last_served ? req_onehot(REQ_SPI)
                             : req_onehot(REQ_PIN);
      (req == 2'b01):
        winner = req_onehot(REQ_SPI);
      (req == 2'b10):
        winner = req_onehot(REQ_PIN);
      default:
        winner = '0;
    endcase
  end

endmodule

// File: rtl/rsa_job_arbiter.sv
// rsa_job_arbiter: grants the RSA engine to SPI or pin requester, one job at a time.
// Define RSA_ARB_TIMEOUT_EN to enable the RUN-state timeout and ABORT path.
module rsa_job_arbiter
  import rsa_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic       clk,
  input  logic       rstb,
  input  logic       ena,
  input  logic [1:0] req,
  input  logic       eoc_in,
  input  logic       err_clr,
  output logic       start_out,
  output logic       stop_out,
  output logic [1:0] grant,
  output logic [1:0] done,
  output logic       busy,
  output logic       timeout_err
);

  state_t     state;
  state_t     state_nxt;
  logic [1:0] grant_nxt;
  logic [1:0] winner;
  logic       last_served;
  logic       last_nxt;
  logic       eoc_s;
  logic       eoc_p;
  logic       eoc_rise;
  logic       fin;

  rsa_rr_pick u_pick (
    .req         (req),
    .last_served (last_served),
    .winner      (winner)
  );

  assign eoc_rise = eoc_s & ~eoc_p;

`ifdef RSA_ARB_TIMEOUT_EN
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt;
  logic             expired;
  logic             err_q;

  assign expired = (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      cnt <= '0;
    end else if (ena) begin
      if (state == ST_START)
        cnt <= '0;
      else if (state == ST_RUN)
        cnt <= cnt + CNT_W'(1);
    end
  end

  // A timeout landing with err_clr still sets the flag.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      err_q <= 1'b0;
    end else if (ena) begin
      if (state == ST_RUN && state_nxt == ST_ABORT)
        err_q <= 1'b1;
      else if (err_clr)
        err_q <= 1'b0;
    end
  end

  assign timeout_err = err_q;
  assign stop_out    = ena & (state == ST_ABORT);
  assign fin         = (state == ST_DONE) | (state == ST_ABORT);
`else
  logic [CNT_W:0] unused_cfg;

  assign unused_cfg  = {err_clr, CNT_W'(TIMEOUT_CYCLES)};
  assign timeout_err = 1'b0;
  assign stop_out    = 1'b0;
  assign fin         = (state == ST_DONE);
`endif

  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    last_nxt  = last_served;
    unique case (state)
      ST_IDLE: begin
        if (|req) begin
          state_nxt = ST_START;
          grant_nxt = winner;
        end
      end
      ST_START: begin
        state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (eoc_rise)
          state_nxt = ST_DONE;
`ifdef RSA_ARB_TIMEOUT_EN
        else if (expired)
          state_nxt = ST_ABORT;
`endif
      end
`ifdef RSA_ARB_TIMEOUT_EN
      ST_DONE, ST_ABORT: begin
`else
      ST_DONE: begin
`endif
        state_nxt = ST_IDLE;
        grant_nxt = '0;
        last_nxt  = grant[REQ_PIN];
      end
      default: begin
        state_nxt = ST_IDLE;
        grant_nxt = '0;
      end
    endcase
  end

  // Leaving START both history taps take the current level,
  // so an eoc already high on RUN entry is never seen as an edge.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state       <= ST_IDLE;
      grant       <= '0;
      last_served <= 1'b1;
      eoc_s       <= 1'b0;
      eoc_p       <= 1'b0;
    end else if (ena) begin
      state       <= state_nxt;
      grant       <= grant_nxt;
      last_served <= last_nxt;
      eoc_s       <= eoc_in;
      eoc_p       <= (state == ST_START) ? eoc_in : eoc_s;
    end
  end

  assign start_out = ena & (state == ST_START);
  assign done      = (ena & fin) ? grant : 2'b00;
  assign busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_rsa_job_arbiter.sv
// tb_rsa_job_arbiter: directed scenarios plus random traffic against a job-level model.
// Build with RSA_ARB_TIMEOUT_EN defined to exercise the abort path (TIMEOUT_CYCLES=8).
module tb_rsa_job_arbiter;

  localparam int TO = 8;
`ifdef RSA_ARB_TIMEOUT_EN
  localparam int JOB_GAP = 4;
`else
  localparam int JOB_GAP = 19;
`endif

  localparam int M_IDLE  = 0;
  localparam int M_START = 1;
  localparam int M_RUN   = 2;
  localparam int M_DONE  = 3;
  localparam int M_ABORT = 4;

  logic       clk = 1'b0;
  logic       rstb = 1'b0;
  logic       ena = 1'b1;
  logic [1:0] req = 2'b00;
  logic       eoc_in = 1'b0;
  logic       err_clr = 1'b0;
  logic       start_out;
  logic       stop_out;
  logic [1:0] grant;
  logic [1:0] done;
  logic       busy;
  logic       timeout_err;

  int checks = 0;
  int failures = 0;

  int ph;
  int owner;
  int last;
  bit err;
  bit hist[$];
  int runcyc;

  always #5 clk = ~clk;

  rsa_job_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk         (clk),
    .rstb        (rstb),
    .ena         (ena),
    .req         (req),
    .eoc_in      (eoc_in),
    .err_clr     (err_clr),
    .start_out   (start_out),
    .stop_out    (stop_out),
    .grant       (grant),
    .done        (done),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_reset();
    ph = M_IDLE;
    owner = 0;
    last = 1;
    err = 0;
    hist.delete();
    runcyc = 0;
  endfunction

  // One enabled clock edge of the job-level behaviour.
  function automatic void model_edge();
    bit rise;
    bit set;
    set = 0;
    rise = 0;
    case (ph)
      M_IDLE: begin
        if (req != 2'b00) begin
          owner = (req == 2'b11) ? 1 - last : (req[0] ? 0 : 1);
          ph = M_START;
        end
      end
      M_START: begin
        hist = {eoc_in};
        runcyc = 0;
        ph = M_RUN;
      end
      M_RUN: begin
        if (hist.size() >= 2)
          rise = hist[$] && !hist[$-1];
        runcyc++;
        if (rise) ph = M_DONE;
`ifdef RSA_ARB_TIMEOUT_EN
        else if (runcyc == TO) begin
          ph = M_ABORT;
          set = 1;
        end
`endif
        hist.push_back(eoc_in);
      end
      default: begin
        last = owner;
        ph = M_IDLE;
      end
    endcase
    if (set) err = 1;
    else if (err_clr) err = 0;
  endfunction

  task automatic check_all();
    logic [1:0] eg;
    logic [1:0] ed;
    eg = (ph == M_IDLE) ? 2'b00 : 2'(1 << owner);
    ed = (ena && (ph == M_DONE || ph == M_ABORT)) ? eg : 2'b00;
    chk("grant", grant, eg);
    chk("busy", busy, ph != M_IDLE);
    chk("start_out", start_out, ena && ph == M_START);
    chk("done", done, ed);
    chk("stop_out", stop_out, ena && ph == M_ABORT);
    chk("timeout_err", timeout_err, err);
  endtask

  task automatic cyc();
    @(posedge clk);
    if (rstb && ena) model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic run_until_done(input int maxc, output int n);
    n = 0;
    do begin
      cyc();
      n++;
    end while (done == 2'b00 && n < maxc);
  endtask

  task automatic do_reset();
    rstb = 1'b0;
    #1;
    model_reset();
    check_all();
    cyc();
    rstb = 1'b1;
  endtask

  initial begin
    int n;
    repeat (2) @(negedge clk);
    model_reset();
    check_all();
    rstb = 1'b1;

    // single job from the SPI path, req dropped during the job
    req = 2'b01;
    cyc();
    chk("job1_start", start_out, 1'b1);
    chk("job1_grant", grant, 2'b01);
    req = 2'b00;
    cyc();
    repeat (JOB_GAP) cyc();
    eoc_in = 1'b1;
    run_until_done(6, n);
    chk("job1_done", done, 2'b01);
    chk("job1_lat", n, 2);
    cyc();
    chk("job1_idle", busy, 1'b0);
    eoc_in = 1'b0;
    cyc();

    // contention straight out of reset: SPI first, then pin
    do_reset();
    req = 2'b11;
    cyc();
    chk("rr_first", grant, 2'b01);
    cyc();
    cyc();
    eoc_in = 1'b1;
    run_until_done(6, n);
    chk("rr_first_done", done, 2'b01);
    eoc_in = 1'b0;
    cyc();
    chk("rr_gap_idle", busy, 1'b0);
    cyc();
    chk("rr_second", grant, 2'b10);
    req = 2'b00;
    cyc();
    cyc();
    eoc_in = 1'b1;
    run_until_done(6, n);
    chk("rr_second_done", done, 2'b10);
    eoc_in = 1'b0;
    cyc();

    // stale eoc level on RUN entry must not complete the job
    eoc_in = 1'b1;
    req = 2'b01;
    cyc();
    req = 2'b00;
    cyc();
    cyc();
    chk("stale_nodone", done, 2'b00);
    eoc_in = 1'b0;
    repeat (4) cyc();
    chk("stale_busy", busy, 1'b1);
    eoc_in = 1'b1;
    run_until_done(6, n);
    chk("stale_done", done, 2'b01);
    chk("stale_lat", n, 2);
    eoc_in = 1'b0;
    cyc();

    // enable held low mid-RUN freezes the job
    req = 2'b10;
    cyc();
    req = 2'b00;
    cyc();
    cyc();
    ena = 1'b0;
    repeat (10) begin
      cyc();
      chk("frz_grant", grant, 2'b10);
    end
    ena = 1'b1;
    cyc();
    eoc_in = 1'b1;
    run_until_done(6, n);
    chk("frz_done", done, 2'b10);
    eoc_in = 1'b0;
    cyc();

    // no eoc edge at all
    req = 2'b01;
    cyc();
    req = 2'b00;
`ifdef RSA_ARB_TIMEOUT_EN
    n = 0;
    do begin
      cyc();
      n++;
    end while (!stop_out && n < 20);
    chk("to_lat", n, TO + 1);
    chk("to_done", done, 2'b01);
    cyc();
    chk("to_err_held", timeout_err, 1'b1);
    err_clr = 1'b1;
    cyc();
    err_clr = 1'b0;
    chk("to_err_clr", timeout_err, 1'b0);
`else
    repeat (12) cyc();
    chk("noto_stop", stop_out, 1'b0);
    chk("noto_busy", busy, 1'b1);
    eoc_in = 1'b1;
    run_until_done(6, n);
    chk("noto_done", done, 2'b01);
    eoc_in = 1'b0;
`endif
    cyc();

    // reset mid-RUN drops the job
    req = 2'b01;
    cyc();
    cyc();
    cyc();
    eoc_in = 1'b1;
    do_reset();
    chk("rst_busy", busy, 1'b0);
    req = 2'b00;
    eoc_in = 1'b0;
    cyc();
    chk("rst_nodone", done, 2'b00);

    // random traffic
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 3) == 0) req = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 5) == 0) eoc_in = ~eoc_in;
      ena = ($urandom_range(0, 9) != 0);
      err_clr = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 499) == 0) do_reset();
      else cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
